// File: rtl/bus_master_if.sv
// Bus master port bundle: command intake, response pulse and the arbitrated
// bus side (req/gnt/ack/data) of one master.
//
// Handshake semantics: a command transfers on a rising edge where
// cmd_valid && cmd_ready are both 1; cmd_sid/cmd_data must be stable while
// cmd_valid is high, and cmd_ready never depends on cmd_valid. rsp_valid is a
// one-cycle pulse with no backpressure. On the bus side, ack and m_data_in
// are shared by all masters and only mean something to this master while it
// is waiting for its own transfer.
interface bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_sid;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        req;
    logic        slave_id;
    logic [31:0] m_data_out;
    logic        gnt;
    logic        ack;
    logic [31:0] m_data_in;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_sid, cmd_data, gnt, ack, m_data_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
               req, slave_id, m_data_out, busy
    );

    modport slave (
        output cmd_valid, cmd_sid, cmd_data, gnt, ack, m_data_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
               req, slave_id, m_data_out, busy
    );
endinterface

// File: rtl/bus_master.sv
// Bus master: queues {sid, data} commands in a small FIFO, then for each one
// requests the bus, waits for grant, waits for ack (or times out), returns a
// response pulse and releases the bus for one cycle before the next command.
module bus_master #(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_master_if.master  bus,
    output logic [1:0]    dbg_state,
    output logic [AW:0]   dbg_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          cur_sid_q, cur_sid_d;
    logic [31:0]   cur_data_q, cur_data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          req_q, req_d;
    logic          slave_id_q, slave_id_d;
    logic [31:0]   m_data_out_q, m_data_out_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    // FIFO storage holds {sid, data}; contents are don't-care until counted
    logic [32:0]   mem_q [DEPTH];

    logic          cmd_ready;
    logic          push;
    logic          pop;
    logic [32:0]   head;

    // Ready is a pure function of occupancy, so a push is refused at full
    // even in a cycle that also pops.
    assign cmd_ready = (count_q < (AW+1)'(DEPTH));
    assign push      = bus.cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // FIFO write port: store the offered command at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_sid, bus.cmd_data};
        end
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Transaction FSM: next state, current command, timeout and response
    always_comb begin
        state_d     = state_q;
        cur_sid_d   = cur_sid_q;
        cur_data_d  = cur_data_q;
        tmo_d       = tmo_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d    = REQ;
                    cur_sid_d  = head[32];
                    cur_data_d = head[31:0];
                end
            end
            REQ: begin
                // ack seen here belongs to another master's transfer
                if (bus.gnt) begin
                    state_d = WAIT;
                    tmo_d   = '0;
                end
            end
            WAIT: begin
                // ack takes priority over a timeout in the same cycle; a
                // dropped gnt does not abort the wait
                if (bus.ack) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.m_data_in;
                    rsp_err_d   = 1'b0;
                    state_d     = RELEASE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'h0;
                    rsp_err_d   = 1'b1;
                    state_d     = RELEASE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered bus outputs follow the state being entered, so req is high
    // exactly while the FSM sits in REQ or WAIT and low through RELEASE.
    always_comb begin
        req_d        = (state_d == REQ) || (state_d == WAIT);
        slave_id_d   = req_d ? cur_sid_d  : 1'b0;
        m_data_out_d = req_d ? cur_data_d : 32'h0;
    end

    // State register; reset drops req at once and empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cur_sid_q    <= 1'b0;
            cur_data_q   <= 32'h0;
            tmo_q        <= '0;
            req_q        <= 1'b0;
            slave_id_q   <= 1'b0;
            m_data_out_q <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cur_sid_q    <= cur_sid_d;
            cur_data_q   <= cur_data_d;
            tmo_q        <= tmo_d;
            req_q        <= req_d;
            slave_id_q   <= slave_id_d;
            m_data_out_q <= m_data_out_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.req        = req_q;
    assign bus.slave_id   = slave_id_q;
    assign bus.m_data_out = m_data_out_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = (state_q != IDLE) || (count_q != '0);

    assign dbg_state = state_q;
    assign dbg_count = count_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: single transfer, FIFO fill and refusal at
// full, timeout, stray ack, ack-vs-timeout race and mid-transfer reset.
module tb_bus_master;

    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int TIMEOUT = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic        clk;
    logic        rst;
    logic [1:0]  dbg_state;
    logic [AW:0] dbg_count;

    int n_vec;
    int n_err;
    int rsp_cnt;
    int rsp_snap;

    logic [31:0] exp_d [6];
    logic        exp_s [6];

    bus_master_if bus ();

    bus_master #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // response pulse counter, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) rsp_cnt++;
    end

    // hard time limit
    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: time limit reached before summary");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic sid, input logic [31:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_sid   = sid;
        bus.cmd_data  = data;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 8 && bus.req !== 1'b1; i++) step();
        chk("wait_req", bus.req, 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rsp_cnt = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_sid   = 1'b0;
        bus.cmd_data  = 32'h0;
        bus.gnt       = 1'b0;
        bus.ack       = 1'b0;
        bus.m_data_in = 32'h0;
        rst = 1'b1;

        // ---- reset state ----
        step();
        step();
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_count", dbg_count, 0);
        chk("rst_req", bus.req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", bus.cmd_ready, 1);

        // ---- single transfer ----
        push(1'b1, 32'h0000_00A5);
        chk("t1_count1", dbg_count, 1);
        chk("t1_busy", bus.busy, 1);
        chk("t1_req_idle", bus.req, 0);
        step();
        chk("t1_state_req", dbg_state, ST_REQ);
        chk("t1_req", bus.req, 1);
        chk("t1_sid", bus.slave_id, 1);
        chk("t1_mdo", bus.m_data_out, 32'h0000_00A5);
        chk("t1_count0", dbg_count, 0);
        bus.gnt = 1'b1;
        step();
        chk("t1_state_wait", dbg_state, ST_WAIT);
        bus.gnt = 1'b0;
        step();
        chk("t1_wait_nogntdrop", dbg_state, ST_WAIT);
        chk("t1_rsp_none", bus.rsp_valid, 0);
        bus.ack = 1'b1;
        bus.m_data_in = 32'h1234_5678;
        step();
        bus.ack = 1'b0;
        chk("t1_rsp_valid", bus.rsp_valid, 1);
        chk("t1_rsp_data", bus.rsp_data, 32'h1234_5678);
        chk("t1_rsp_err", bus.rsp_err, 0);
        chk("t1_state_rel", dbg_state, ST_RELEASE);
        chk("t1_req_rel", bus.req, 0);
        chk("t1_mdo_rel", bus.m_data_out, 0);
        step();
        chk("t1_rsp_pulse", bus.rsp_valid, 0);
        chk("t1_rsp_hold", bus.rsp_data, 32'h1234_5678);
        chk("t1_state_idle", dbg_state, ST_IDLE);
        chk("t1_busy_done", bus.busy, 0);
        chk("t1_rsp_cnt", rsp_cnt, 1);

        // ---- fill the FIFO with gnt low ----
        exp_d[0] = 32'h11; exp_s[0] = 1'b1;
        exp_d[1] = 32'h22; exp_s[1] = 1'b0;
        exp_d[2] = 32'h33; exp_s[2] = 1'b1;
        exp_d[3] = 32'h44; exp_s[3] = 1'b0;
        exp_d[4] = 32'h55; exp_s[4] = 1'b1;
        exp_d[5] = 32'h66; exp_s[5] = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_sid  = exp_s[i];
            bus.cmd_data = exp_d[i];
            step();
        end
        // first command popped on the second push edge, four still queued
        chk("t2_count_full", dbg_count, 4);
        chk("t2_ready_full", bus.cmd_ready, 0);
        chk("t2_state_req", dbg_state, ST_REQ);
        chk("t2_mdo0", bus.m_data_out, exp_d[0]);
        chk("t2_sid0", bus.slave_id, exp_s[0]);
        bus.cmd_sid  = exp_s[5];
        bus.cmd_data = exp_d[5];
        step();
        chk("t2_refused", dbg_count, 4);
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        bus.ack = 1'b1;
        bus.m_data_in = 32'hA000_0000 | exp_d[0];
        step();
        bus.ack = 1'b0;
        chk("t2_rsp0_valid", bus.rsp_valid, 1);
        chk("t2_rsp0_data", bus.rsp_data, 32'hA000_0011);
        step();
        chk("t2_idle_full", dbg_state, ST_IDLE);
        chk("t2_idle_count", dbg_count, 4);
        chk("t2_idle_ready", bus.cmd_ready, 0);
        step();
        // pop with a refused push at full: occupancy drops by one
        chk("t2_pop_count", dbg_count, 3);
        chk("t2_pop_state", dbg_state, ST_REQ);
        chk("t2_pop_ready", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        chk("t2_push5_count", dbg_count, 4);
        for (int k = 1; k < 6; k++) begin
            wait_req();
            chk("t2_mdo_order", bus.m_data_out, exp_d[k]);
            chk("t2_sid_order", bus.slave_id, exp_s[k]);
            bus.gnt = 1'b1;
            step();
            bus.gnt = 1'b0;
            chk("t2_wait", dbg_state, ST_WAIT);
            bus.ack = 1'b1;
            bus.m_data_in = 32'hA000_0000 | exp_d[k];
            step();
            bus.ack = 1'b0;
            chk("t2_rsp_valid", bus.rsp_valid, 1);
            chk("t2_rsp_data", bus.rsp_data, 32'hA000_0000 | exp_d[k]);
            step();
        end
        chk("t2_rsp_cnt", rsp_cnt, 7);
        chk("t2_empty", dbg_count, 0);

        // ---- timeout with gnt held ----
        push(1'b0, 32'h77);
        wait_req();
        bus.gnt = 1'b1;
        step();
        chk("t3_wait", dbg_state, ST_WAIT);
        repeat (TIMEOUT - 1) step();
        chk("t3_no_rsp_early", bus.rsp_valid, 0);
        chk("t3_still_wait", dbg_state, ST_WAIT);
        step();
        chk("t3_rsp_valid", bus.rsp_valid, 1);
        chk("t3_rsp_err", bus.rsp_err, 1);
        chk("t3_rsp_data", bus.rsp_data, 0);
        chk("t3_req_rel", bus.req, 0);
        chk("t3_state_rel", dbg_state, ST_RELEASE);
        bus.gnt = 1'b0;
        step();
        chk("t3_rsp_pulse", bus.rsp_valid, 0);
        chk("t3_err_hold", bus.rsp_err, 1);
        chk("t3_idle", dbg_state, ST_IDLE);

        // ---- stray ack in IDLE and REQ ----
        rsp_snap = rsp_cnt;
        bus.ack = 1'b1;
        bus.m_data_in = 32'hDEAD_BEEF;
        step();
        bus.ack = 1'b0;
        chk("t4_idle_ack_state", dbg_state, ST_IDLE);
        chk("t4_idle_ack_rsp", bus.rsp_valid, 0);
        push(1'b1, 32'h88);
        step();
        chk("t4_req", dbg_state, ST_REQ);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("t4_req_ack_state", dbg_state, ST_REQ);
        chk("t4_req_ack_rsp", bus.rsp_valid, 0);
        step();
        chk("t4_rsp_cnt", rsp_cnt, rsp_snap);

        // ---- ack on the last timeout cycle wins ----
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        chk("t5_wait", dbg_state, ST_WAIT);
        repeat (TIMEOUT - 1) step();
        chk("t5_still_wait", dbg_state, ST_WAIT);
        bus.ack = 1'b1;
        bus.m_data_in = 32'hCAFE_F00D;
        step();
        bus.ack = 1'b0;
        chk("t5_rsp_valid", bus.rsp_valid, 1);
        chk("t5_rsp_err", bus.rsp_err, 0);
        chk("t5_rsp_data", bus.rsp_data, 32'hCAFE_F00D);
        step();

        // ---- reset in WAIT with two entries queued ----
        bus.cmd_valid = 1'b1;
        bus.cmd_sid   = 1'b0; bus.cmd_data = 32'h99; step();
        bus.cmd_sid   = 1'b1; bus.cmd_data = 32'hAA; step();
        bus.cmd_sid   = 1'b0; bus.cmd_data = 32'hBB; step();
        bus.cmd_valid = 1'b0;
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        chk("t6_wait", dbg_state, ST_WAIT);
        chk("t6_queued", dbg_count, 2);
        chk("t6_req_before", bus.req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_async", bus.req, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_count", dbg_count, 0);
        chk("t6_state", dbg_state, ST_IDLE);
        chk("t6_ready", bus.cmd_ready, 1);
        chk("t6_rsp_data_clr", bus.rsp_data, 0);
        step();
        rst = 1'b0;
        rsp_snap = rsp_cnt;
        bus.ack = 1'b1;
        bus.m_data_in = 32'h5555_AAAA;
        repeat (5) step();
        bus.ack = 1'b0;
        chk("t6_no_rsp", rsp_cnt, rsp_snap);
        chk("t6_idle_after", dbg_state, ST_IDLE);
        chk("t6_req_after", bus.req, 0);
        chk("t6_busy_after", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
